// File: rtl/dg_stack_pkg.sv
// dg_stack_pkg: shared op encoding, overflow policy constants and occupancy width helper for the return stack
package dg_stack_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        POP  = 2'b01,
        PUSH = 2'b10,
        REPL = 2'b11
    } stk_op_t;

    localparam int OVF_DISCARD = 0;
    localparam int OVF_REJECT  = 1;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dg_stack_occ.sv
// dg_stack_occ: saturating occupancy counter with full/empty decode and overflow/underflow pulses
//   clk, RESET (async, active-low)
//   op      : decoded stack operation
//   occ     : valid entry count, 0..DEPTH
//   empty   : occ == 0, full : occ == DEPTH
//   ovf/unf : registered one-cycle pulses for push-while-full / pop-while-empty
//   push_en : the entry array should shift down this cycle (a push not rejected by OVF_MODE)
module dg_stack_occ import dg_stack_pkg::*; #(
    parameter int DEPTH    = 5,
    parameter int OVF_MODE = OVF_DISCARD
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  stk_op_t                   op,
    output logic [occ_w(DEPTH)-1:0]   occ,
    output logic                      empty,
    output logic                      full,
    output logic                      ovf,
    output logic                      unf,
    output logic                      push_en
);

    localparam int OW = occ_w(DEPTH);

    assign empty   = occ == '0;
    assign full    = occ == OW'(DEPTH);
    assign push_en = op == PUSH && !(full && OVF_MODE == OVF_REJECT);

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            occ <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            occ <= op == PUSH ? (full ? occ : occ + 1'b1) :
                   op == POP  ? (empty ? occ : occ - 1'b1) :
                   op == REPL && empty ? OW'(1) : occ;
            ovf <= op == PUSH && full;
            unf <= op == POP && empty;
        end
    end

endmodule

// File: rtl/dg_ret_stack.sv
// dg_ret_stack: parametrised return-address stack with occupancy, overflow policy and replace op
//   clk, RESET (async, active-low)
//   push, pop, push_data : {push,pop} = 10 push, 01 pop, 11 replace top, 00 hold
//   top                  : entry 0, registered
//   occ, empty, full     : occupancy status
//   ovf, unf             : one-cycle error pulses
//   err_clr, err_ovf, err_unf : sticky error flags, built only when DG_STACK_ERR_EN is defined
module dg_ret_stack import dg_stack_pkg::*; #(
    parameter int PC_W     = 10,
    parameter int DEPTH    = 5,
    parameter int OVF_MODE = OVF_DISCARD
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    push,
    input  logic                    pop,
    input  logic [PC_W-1:0]         push_data,
    output logic [PC_W-1:0]         top,
    output logic [occ_w(DEPTH)-1:0] occ,
    output logic                    empty,
    output logic                    full,
    output logic                    ovf,
    output logic                    unf,
    input  logic                    err_clr,
    output logic                    err_ovf,
    output logic                    err_unf
);

    localparam int N = DEPTH * PC_W;

    stk_op_t      op;
    logic         push_en;
    logic [N-1:0] st;

    assign op  = stk_op_t'({push, pop});
    assign top = st[PC_W-1:0];

    dg_stack_occ #(.DEPTH(DEPTH), .OVF_MODE(OVF_MODE)) u_occ (
        .clk     (clk),
        .RESET   (RESET),
        .op      (op),
        .occ     (occ),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf),
        .push_en (push_en)
    );

    // Entry 0 sits in the low slice; a pop refills the bottom slot with its own value.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET)
            st <= '0;
        else if (push_en)
            st <= {st[N-PC_W-1:0], push_data};
        else if (op == POP)
            st <= {st[N-1 -: PC_W], st[N-1:PC_W]};
        else if (op == REPL)
            st[PC_W-1:0] <= push_data;
    end

`ifdef DG_STACK_ERR_EN
    // Set takes priority over a coincident clear.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= (op == PUSH && full) || (err_ovf && !err_clr);
            err_unf <= (op == POP && empty) || (err_unf && !err_clr);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

endmodule

// File: tb/tb_dg_ret_stack.sv
// tb_dg_ret_stack: directed checks of both overflow policies sharing one stimulus stream
module tb_dg_ret_stack;

`ifdef DG_STACK_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       RESET = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [9:0] push_data = '0;
    logic [9:0] top0, top1;
    logic [2:0] occ0, occ1;
    logic       empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;
    logic       eo0, eo1, eu0, eu1;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    dg_ret_stack #(.PC_W(10), .DEPTH(5), .OVF_MODE(0)) dut0 (
        .clk(clk), .RESET(RESET), .push(push), .pop(pop), .push_data(push_data),
        .top(top0), .occ(occ0), .empty(empty0), .full(full0), .ovf(ovf0), .unf(unf0),
        .err_clr(err_clr), .err_ovf(eo0), .err_unf(eu0)
    );

    dg_ret_stack #(.PC_W(10), .DEPTH(5), .OVF_MODE(1)) dut1 (
        .clk(clk), .RESET(RESET), .push(push), .pop(pop), .push_data(push_data),
        .top(top1), .occ(occ1), .empty(empty1), .full(full1), .ovf(ovf1), .unf(unf1),
        .err_clr(err_clr), .err_ovf(eo1), .err_unf(eu1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic p, input logic q, input logic [9:0] d);
        push = p;
        pop = q;
        push_data = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_top0"}, 32'(top0), 0);
        chk({tag, "_top1"}, 32'(top1), 0);
        chk({tag, "_occ0"}, 32'(occ0), 0);
        chk({tag, "_occ1"}, 32'(occ1), 0);
        chk({tag, "_flags0"}, {26'd0, empty0, full0, ovf0, unf0, eo0, eu0}, 32'b100000);
        chk({tag, "_flags1"}, {26'd0, empty1, full1, ovf1, unf1, eo1, eu1}, 32'b100000);
    endtask

    initial begin
        #12;
        chk_reset("reset");
        @(negedge clk);
        RESET = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            op(1'b1, 1'b0, 10'(i));
            chk($sformatf("push%0d_top", i), 32'(top0), i);
            chk($sformatf("push%0d_occ", i), 32'(occ1), i);
        end
        chk("full0", 32'(full0), 1);
        chk("full1", 32'(full1), 1);
        chk("ovf_before", 32'({ovf0, ovf1}), 0);
        op(1'b1, 1'b0, 10'h3FF);
        chk("ovf_top0", 32'(top0), 32'h3FF);
        chk("ovf_top1", 32'(top1), 32'h005);
        chk("ovf_pulse", 32'({ovf0, ovf1}), 32'b11);
        chk("ovf_occ", 32'({occ0, occ1}), {26'd0, 3'd5, 3'd5});
        chk("err_ovf_set", 32'({eo0, eo1}), {30'd0, ERR, ERR});
        op(1'b0, 1'b0, 10'h000);
        chk("ovf_drop", 32'({ovf0, ovf1}), 0);
        chk("err_ovf_hold", 32'({eo0, eo1}), {30'd0, ERR, ERR});
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pop%0d_top0", i), 32'(top0), i == 0 ? 32'h3FF : 32'(5 - i + 1));
            chk($sformatf("pop%0d_top1", i), 32'(top1), 32'(5 - i));
            op(1'b0, 1'b1, 10'h000);
        end
        chk("popped_empty", 32'({empty0, empty1, occ0, occ1}), {24'd0, 2'b11, 6'd0});
        chk("popped_top0", 32'(top0), 2);
        chk("popped_top1", 32'(top1), 1);
        chk("unf_before", 32'({unf0, unf1}), 0);
        op(1'b0, 1'b1, 10'h000);
        chk("unf_pulse", 32'({unf0, unf1}), 32'b11);
        chk("unf_occ", 32'({occ0, occ1}), 0);
        chk("unf_top", 32'({top0, top1}), {12'd0, 10'h002, 10'h001});
        chk("err_unf_set", 32'({eu0, eu1}), {30'd0, ERR, ERR});
        op(1'b0, 1'b0, 10'h000);
        chk("unf_drop", 32'({unf0, unf1}), 0);
        chk("err_unf_hold", 32'({eu0, eu1}), {30'd0, ERR, ERR});
        err_clr = 1'b1;
        op(1'b0, 1'b0, 10'h000);
        chk("err_cleared", 32'({eo0, eo1, eu0, eu1}), 0);
        op(1'b1, 1'b0, 10'h020);
        op(1'b1, 1'b0, 10'h010);
        chk("pre_repl", 32'({top0, occ0}), {19'd0, 10'h010, 3'd2});
        op(1'b1, 1'b1, 10'h155);
        chk("repl_top0", 32'({top0, occ0}), {19'd0, 10'h155, 3'd2});
        chk("repl_top1", 32'({top1, occ1}), {19'd0, 10'h155, 3'd2});
        chk("repl_noerr", 32'({ovf0, unf0, ovf1, unf1}), 0);
        op(1'b0, 1'b1, 10'h000);
        chk("repl_pop", 32'({top0, occ1}), {19'd0, 10'h020, 3'd1});
        op(1'b0, 1'b1, 10'h000);
        chk("empty_again", 32'({top0, top1, occ0}), {9'd0, 10'h002, 10'h001, 3'd0});
        op(1'b1, 1'b1, 10'h077);
        chk("repl_empty", 32'({top0, occ0, empty0}), {18'd0, 10'h077, 3'd1, 1'b0});
        chk("repl_empty_noerr", 32'({ovf0, unf0}), 0);
        push = 1'b1;
        push_data = 10'h0AA;
        #2;
        RESET = 1'b0;
        #1;
        chk_reset("async_rst");
        @(posedge clk);
        #1;
        chk_reset("held_rst");
        push = 1'b0;
        @(negedge clk);
        RESET = 1'b1;
        op(1'b1, 1'b0, 10'h0AA);
        chk("post_rst0", 32'({top0, occ0}), {19'd0, 10'h0AA, 3'd1});
        chk("post_rst1", 32'({top1, occ1}), {19'd0, 10'h0AA, 3'd1});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dg_ret_stack.md
# dg_ret_stack

Parametrised return-address stack for the DG00xx 4-bit controller family, replacing the fixed five-level, 10-bit shift-register stack used by CALL/RET/RETSK. Adds configurable depth and width, an occupancy counter, full/empty status, a same-cycle replace operation, a selectable overflow policy and optional sticky error flags. It sits beside the program counter: the PC group pushes on CALL, pops on RET/RETSK and loads the PC from `top`.

## Interface
Parameters:
- `PC_W`, 10: width of one stack entry (PU+PL).
- `DEPTH`, 5: number of entries, 2..16.
- `OVF_MODE`, 0: 0 = push on full discards the oldest entry; 1 = push on full is rejected and the stack holds.

Ports:
- `clk`  in  1: stack clock. The PC group gates it to the former STK_CLK edge.
- `RESET`  in  1: asynchronous, active-low reset.
- `push`  in  1: push `push_data` this cycle.
- `pop`  in  1: pop the top entry this cycle.
- `push_data`  in  PC_W: return address to store.
- `top`  out  PC_W: current top entry, registered.
- `occ`  out  $clog2(DEPTH+1): number of valid entries.
- `empty`  out  1: high when `occ`==0.
- `full`  out  1: high when `occ`==DEPTH.
- `ovf`  out  1: one-cycle pulse on a push while full.
- `unf`  out  1: one-cycle pulse on a pop while empty.
- `err_clr`  in  1: clears the sticky flags (used only with DG_STACK_ERR_EN).
- `err_ovf`, `err_unf`  out  1 each: sticky error flags.

## Operation
- Storage is an entry array e[0..DEPTH-1], with e[0] as the top. `top` = e[0].
- The operation is decoded from {push,pop}:
  - NONE (00): hold.
  - PUSH (10):
    - Not full: shift down (e[i]<=e[i-1]), e[0]<=push_data, occ+1.
    - Full, OVF_MODE=0: same shift, e[DEPTH-1] is lost, occ stays DEPTH, `ovf`=1.
    - Full, OVF_MODE=1: array and occ hold, `ovf`=1.
  - POP (01):
    - Shift up (e[i]<=e[i+1]). The bottom entry is duplicated into itself.
    - occ-1 if nonzero.
    - Empty: the shift still happens, occ stays 0, `unf`=1. RET on an empty stack therefore returns the duplicated bottom value, matching legacy behaviour.
  - REPL (11): e[0]<=push_data, other entries hold, occ unchanged.
    - Empty: occ becomes 1.
    - REPL never raises `ovf` or `unf`.
- `empty` and `full` are decoded from `occ`.
- `occ` never exceeds DEPTH and never wraps below 0.

## Timing
- All state updates on the rising edge of `clk`. Zero-cycle read: `top` reflects a push or pop immediately after the edge.
- `ovf` and `unf` are registered and high for exactly the one cycle after the offending edge.
- Back-to-back operations on consecutive edges are legal with no bubble.
- Reset values: every e[i]=0, `top`=0, `occ`=0, `empty`=1, `full`=0, `ovf`=`unf`=0, `err_ovf`=`err_unf`=0.
- Reset asserted mid-operation clears everything asynchronously. The first edge after release acts normally.

## Configuration
- Macro `DG_STACK_ERR_EN`.
- Defined: `err_ovf` and `err_unf` set on the same edge as `ovf`/`unf` and stay set until `err_clr`=1 at an edge.
  - If set and clear coincide, set wins.
- Undefined: no sticky registers are built, `err_ovf` and `err_unf` are tied 0, and `err_clr` is ignored.
- `ovf` and `unf` exist in both builds.

## Structure
- Shared package `dg_stack_pkg`:
  - Op enum `stk_op_t` {NONE, PUSH, POP, REPL}.
  - Constants `OVF_DISCARD`=0 and `OVF_REJECT`=1.
  - Function `occ_w(depth)`.
- One sub-module `dg_stack_occ`: saturating occupancy counter that produces `occ`, `empty`, `full`, `ovf` and `unf` from the op and OVF_MODE.
- The entry array stays in the top level.

## Test plan
- Reset, then 5 pushes of 0x001..0x005 (DEPTH=5) -> `top`=0x005, `occ`=5, `full`=1. Five pops return 0x005..0x001 and end with `empty`=1.
- Full, OVF_MODE=0, push 0x3FF -> `top`=0x3FF, `ovf` pulses once, `occ`=5. Five pops return 0x3FF,0x005,0x004,0x003,0x002.
- Full, OVF_MODE=1, push 0x3FF -> `ovf` pulses, `top` stays 0x005, contents unchanged.
- Empty, then pop -> `unf` pulses, `occ`=0. With DG_STACK_ERR_EN, `err_unf` stays 1 until `err_clr`.
- `occ`=2, `top`=0x010, then push=pop=1 with data 0x155 -> `top`=0x155, `occ`=2, next pop -> the old second entry.
- RESET low while push is held high -> all outputs return to their reset values at once. After release, one push of 0x0AA -> `occ`=1, `top`=0x0AA.
